// File: rtl/subrom_flash_loader.sv
// subrom_flash_loader
// Boot-time loader: issues a single SPI READ (0x03) burst starting at FLASH_BASE,
// assembles MISO bytes MSB first and writes each byte into the sub-ROM block RAM.
// busy holds the CPU/reset sequencer off until the image is in place; done then
// stays high until the next start or reset.
// Optional feature macro: SUBROM_LOADER_CHECKSUM_EN adds a 16-bit running byte
// sum output (checksum) accumulated on every RAM write.
module subrom_flash_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int unsigned ROM_BYTES  = 16384,
  parameter int unsigned SCK_DIV    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [13:0] rom_address,
  output logic [7:0]  rom_data,
  output logic        rom_wren,
  output logic        busy,
  output logic        done
`ifdef SUBROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [31:0] CMD_WORD  = {8'h03, FLASH_BASE};
  localparam logic [13:0] LAST_ADDR = 14'(ROM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic               r_cs_n;
  logic               r_sck;
  logic               r_mosi;
  logic [13:0]        r_rom_address;
  logic [7:0]         r_rom_data;
  logic               r_rom_wren;
  logic               r_busy;
  logic               r_done;
  logic [30:0]        r_shift;
  logic [7:0]         r_byte;
  logic [DIV_W-1:0]   r_div;
  logic [5:0]         r_bit_cnt;
  logic               w_div_end;
`ifdef SUBROM_LOADER_CHECKSUM_EN
  logic [15:0]        r_checksum;
`endif

  assign w_div_end   = (r_div == DIV_W'(SCK_DIV - 1));

  assign spi_cs_n    = r_cs_n;
  assign spi_sck     = r_sck;
  assign spi_mosi    = r_mosi;
  assign rom_address = r_rom_address;
  assign rom_data    = r_rom_data;
  assign rom_wren    = r_rom_wren;
  assign busy        = r_busy;
  assign done        = r_done;
`ifdef SUBROM_LOADER_CHECKSUM_EN
  assign checksum    = r_checksum;
`endif

  // Load sequencer: command phase, byte reception, RAM write and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cs_n        <= 1'b1;
      r_sck         <= 1'b0;
      r_mosi        <= 1'b0;
      r_rom_address <= '0;
      r_rom_data    <= '0;
      r_rom_wren    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shift       <= '0;
      r_byte        <= '0;
      r_div         <= '0;
      r_bit_cnt     <= '0;
`ifdef SUBROM_LOADER_CHECKSUM_EN
      r_checksum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rom_wren <= 1'b0;
          if (start) begin
            r_cs_n        <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_rom_address <= '0;
            r_mosi        <= CMD_WORD[31];
            r_shift       <= CMD_WORD[30:0];
            r_sck         <= 1'b0;
            r_div         <= '0;
            r_bit_cnt     <= '0;
`ifdef SUBROM_LOADER_CHECKSUM_EN
            r_checksum    <= '0;
`endif
            r_state       <= S_CMD;
          end
        end

        S_CMD: begin
          if (w_div_end) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
              // falling edge: present the next command/address bit
              r_shift <= {r_shift[29:0], 1'b0};
              if (r_bit_cnt == 6'd31) begin
                r_mosi    <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= S_DATA;
              end else begin
                r_mosi    <= r_shift[30];
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_DATA: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck     <= 1'b1;
              r_byte    <= {r_byte[6:0], spi_miso};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end else begin
              r_sck <= 1'b0;
              // The 8th high phase is completed before writing so SCK keeps
              // full half-periods; the write cycle then runs with SCK low.
              if (r_bit_cnt == 6'd8) begin
                r_rom_data <= r_byte;
                r_rom_wren <= 1'b1;
                r_state    <= S_WRITE;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_WRITE: begin
          r_rom_wren <= 1'b0;
`ifdef SUBROM_LOADER_CHECKSUM_EN
          r_checksum <= r_checksum + {8'h00, r_rom_data};
`endif
          if (r_rom_address == LAST_ADDR) begin
            r_state <= S_FINISH;
          end else begin
            r_rom_address <= r_rom_address + 14'd1;
            r_bit_cnt     <= '0;
            r_div         <= '0;
            r_state       <= S_DATA;
          end
        end

        S_FINISH: begin
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subrom_flash_loader.sv
// tb_subrom_flash_loader
// Three loaders (SCK_DIV = 2, 1, 4; 16-byte image) each talk to a behavioural
// SPI flash model. Scenario vectors come from a table; reset-abort and
// start/reset collision are hand-written sequences.
module tb_subrom_flash_loader;

  localparam logic [23:0] FLASH_BASE = 24'h100000;
  localparam int          NBYTES     = 16;
  localparam logic [31:0] EXP_CMD    = {8'h03, FLASH_BASE};
  localparam int          WBUF       = 256;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] r_start = '0;
  logic [2:0] r_reset = '1;
  logic [2:0] r_miso  = '0;

  wire [2:0]  w_cs_n, w_sck, w_mosi, w_wren, w_busy, w_done;
  wire [13:0] w_addr [3];
  wire [7:0]  w_data [3];
`ifdef SUBROM_LOADER_CHECKSUM_EN
  wire [15:0] w_csum [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    subrom_flash_loader #(
      .FLASH_BASE(FLASH_BASE),
      .ROM_BYTES (NBYTES),
      .SCK_DIV   (DIV)
    ) u_dut (
      .clock      (clock),
      .reset      (r_reset[g]),
      .start      (r_start[g]),
      .spi_cs_n   (w_cs_n[g]),
      .spi_sck    (w_sck[g]),
      .spi_mosi   (w_mosi[g]),
      .spi_miso   (r_miso[g]),
      .rom_address(w_addr[g]),
      .rom_data   (w_data[g]),
      .rom_wren   (w_wren[g]),
      .busy       (w_busy[g]),
      .done       (w_done[g])
`ifdef SUBROM_LOADER_CHECKSUM_EN
      ,
      .checksum   (w_csum[g])
`endif
    );
  end

  // Flash image shared by all three flash models
  logic [7:0] mem [NBYTES];

  // Flash model and RAM write recorder state
  int unsigned wr_cnt   [3] = '{default: 0};
  logic [13:0] wr_addr  [3][WBUF];
  logic [7:0]  wr_data  [3][WBUF];
  int unsigned rise_cnt [3] = '{default: 0};
  int unsigned fall_cnt [3] = '{default: 0};
  int unsigned cmd_cnt  [3] = '{default: 0};
  logic [31:0] cmd_word [3] = '{default: 0};
  logic [2:0]  prev_sck = '0;
  logic [2:0]  prev_cs  = '1;

  // Behavioural SPI flash (mode 0) plus RAM write capture, evaluated mid-cycle
  always @(negedge clock) begin
    int unsigned k;
    for (int i = 0; i < 3; i++) begin
      if (w_cs_n[i]) begin
        rise_cnt[i] = 0;
        fall_cnt[i] = 0;
        r_miso[i]   = 1'b0;
      end else begin
        if (prev_cs[i]) begin
          cmd_cnt[i]++;
          cmd_word[i] = '0;
        end
        if (w_sck[i] && !prev_sck[i]) begin
          if (rise_cnt[i] < 32) cmd_word[i] = {cmd_word[i][30:0], w_mosi[i]};
          rise_cnt[i]++;
        end
        if (!w_sck[i] && prev_sck[i]) begin
          fall_cnt[i]++;
          if (fall_cnt[i] >= 32) begin
            k = fall_cnt[i] - 32;
            if (k / 8 < NBYTES) r_miso[i] = mem[k / 8][7 - (k % 8)];
            else                r_miso[i] = 1'b0;
          end
        end
      end
      if (w_wren[i]) begin
        wr_addr[i][wr_cnt[i] % WBUF] = w_addr[i];
        wr_data[i][wr_cnt[i] % WBUF] = w_data[i];
        wr_cnt[i]++;
      end
      prev_sck[i] = w_sck[i];
      prev_cs[i]  = w_cs_n[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_mem(input int pat);
    for (int j = 0; j < NBYTES; j++) begin
      case (pat)
        0:       mem[j] = 8'(j) ^ 8'h5A;
        1:       mem[j] = 8'hFF;
        2:       mem[j] = 8'($urandom_range(0, 255));
        default: mem[j] = 8'h00;
      endcase
    end
  endtask

  // One start pulse, optional extra starts at given write counts, then checks
  task automatic run_load(input int i, input int ea, input int eb,
                          input int exp_w, input int exp_c);
    int unsigned base_w, base_c, n;
    bit pa, pb, finished;
    int sum;
    base_w = wr_cnt[i];
    base_c = cmd_cnt[i];
    r_start[i] = 1'b1;
    tick();
    r_start[i] = 1'b0;
    chk("start_busy", 32'(w_busy[i]), 32'd1);
    chk("start_done_clr", 32'(w_done[i]), 32'd0);
    chk("start_cs_low", 32'(w_cs_n[i]), 32'd0);
    pa = 0; pb = 0; finished = 0;
    for (int c = 0; c < 6000; c++) begin
      n = wr_cnt[i] - base_w;
      if (!pa && ea >= 0 && n == 32'(ea)) begin
        r_start[i] = 1'b1; pa = 1;
      end else if (!pb && eb >= 0 && n == 32'(eb)) begin
        r_start[i] = 1'b1; pb = 1;
      end
      tick();
      r_start[i] = 1'b0;
      if (w_done[i]) begin
        finished = 1;
        break;
      end
    end
    chk("done_reached", 32'(finished), 32'd1);
    repeat (5) tick();
    chk("write_count", wr_cnt[i] - base_w, 32'(exp_w));
    for (int j = 0; j < exp_w; j++) begin
      chk($sformatf("wr_addr[%0d]", j), 32'(wr_addr[i][(base_w + j) % WBUF]), 32'(j));
      chk($sformatf("wr_data[%0d]", j), 32'(wr_data[i][(base_w + j) % WBUF]), 32'(mem[j]));
    end
    chk("cmd_count", cmd_cnt[i] - base_c, 32'(exp_c));
    chk("cmd_word", cmd_word[i], EXP_CMD);
    chk("end_cs_n", 32'(w_cs_n[i]), 32'd1);
    chk("end_sck", 32'(w_sck[i]), 32'd0);
    chk("end_mosi", 32'(w_mosi[i]), 32'd0);
    chk("end_busy", 32'(w_busy[i]), 32'd0);
    chk("end_done", 32'(w_done[i]), 32'd1);
    chk("end_wren", 32'(w_wren[i]), 32'd0);
    chk("end_addr", 32'(w_addr[i]), 32'(NBYTES - 1));
    sum = 0;
    for (int j = 0; j < NBYTES; j++) sum += int'(mem[j]);
`ifdef SUBROM_LOADER_CHECKSUM_EN
    chk("checksum", 32'(w_csum[i]), 32'(sum[15:0]));
`else
    if (sum < 0) $display("negative sum %0d", sum);
`endif
  endtask

  typedef struct {
    int pat;       // image pattern: 0 n^5A, 1 all FF, 2 random, 3 zero
    int extra_a;   // extra start after this many writes (-1 none)
    int extra_b;
    int exp_writes;
    int exp_cmds;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int unsigned base_w, wc;
    bit reached;

    vecs[0] = '{0, -1, -1, NBYTES, 1};
    vecs[1] = '{0,  3, 10, NBYTES, 1};
    vecs[2] = '{1, -1, -1, NBYTES, 1};
    vecs[3] = '{2, -1, -1, NBYTES, 1};
    vecs[4] = '{2,  0, 15, NBYTES, 1};
    fill_mem(3);

    r_reset = '1;
    r_start = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs_n", 32'(w_cs_n[i]), 32'd1);
      chk("rst_sck",  32'(w_sck[i]),  32'd0);
      chk("rst_mosi", 32'(w_mosi[i]), 32'd0);
      chk("rst_wren", 32'(w_wren[i]), 32'd0);
      chk("rst_busy", 32'(w_busy[i]), 32'd0);
      chk("rst_done", 32'(w_done[i]), 32'd0);
      chk("rst_addr", 32'(w_addr[i]), 32'd0);
      chk("rst_data", 32'(w_data[i]), 32'd0);
    end
    r_reset = '0;
    tick();

    for (int i = 0; i < 3; i++) begin
      for (int v = 0; v < 5; v++) begin
        fill_mem(vecs[v].pat);
        run_load(i, vecs[v].extra_a, vecs[v].extra_b, vecs[v].exp_writes, vecs[v].exp_cmds);
      end

      // Reset while byte 5 is being received, then a fresh load
      fill_mem(0);
      base_w = wr_cnt[i];
      r_start[i] = 1'b1;
      tick();
      r_start[i] = 1'b0;
      reached = 0;
      for (int c = 0; c < 6000; c++) begin
        if (wr_cnt[i] - base_w >= 5) begin
          reached = 1;
          break;
        end
        tick();
      end
      chk("abort_reached_byte5", 32'(reached), 32'd1);
      repeat (3) tick();
      r_reset[i] = 1'b1;
      tick();
      chk("abort_cs_n", 32'(w_cs_n[i]), 32'd1);
      chk("abort_sck",  32'(w_sck[i]),  32'd0);
      chk("abort_busy", 32'(w_busy[i]), 32'd0);
      chk("abort_done", 32'(w_done[i]), 32'd0);
      chk("abort_wren", 32'(w_wren[i]), 32'd0);
      chk("abort_addr", 32'(w_addr[i]), 32'd0);
      chk("abort_data", 32'(w_data[i]), 32'd0);
      r_reset[i] = 1'b0;
      chk("abort_partial_writes", wr_cnt[i] - base_w, 32'd5);
      wc = wr_cnt[i];
      repeat (40) tick();
      chk("abort_no_wren", wr_cnt[i], wc);
      chk("abort_idle_cs_n", 32'(w_cs_n[i]), 32'd1);
      run_load(i, -1, -1, NBYTES, 1);

      // start and reset together: reset wins
      r_start[i] = 1'b1;
      r_reset[i] = 1'b1;
      tick();
      r_start[i] = 1'b0;
      r_reset[i] = 1'b0;
      chk("collide_busy", 32'(w_busy[i]), 32'd0);
      chk("collide_cs_n", 32'(w_cs_n[i]), 32'd1);
      chk("collide_done", 32'(w_done[i]), 32'd0);
      repeat (4) tick();
      chk("collide_still_idle", 32'(w_busy[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
